// File: rtl/div_clock_monitor.sv
// div_clock_monitor: measures the high/low run lengths of a divided clock
// sampled as data in the clk domain, and checks them against expected values.
// Reports per-period measurements, a lock indication and a sticky error.
module div_clock_monitor #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  input  logic             err_clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_low,
  output logic             locked,
  output logic             err
);

  localparam int unsigned MW = 8;
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_PERIODS);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             div_q;
  logic [CNT_W-1:0] run_cnt, run_nx;
  logic [CNT_W-1:0] hi_len, hi_nx;
  logic [CNT_W-1:0] mh_nx, ml_nx;
  logic [MW-1:0]    match_cnt, match_nx, match_inc;
  logic             mv_nx, lk_nx, err_nx;
  logic             rise, fall, run_sat, match, set_err;

  // Next-state, run counting, period check and output next values.
  always_comb begin
    state_nx  = state;
    run_nx    = run_cnt;
    hi_nx     = hi_len;
    match_nx  = match_cnt;
    mv_nx     = 1'b0;
    mh_nx     = meas_high;
    ml_nx     = meas_low;
    lk_nx     = locked;
    set_err   = 1'b0;
    err_nx    = err;

    rise      = div_in & ~div_q;
    fall      = ~div_in & div_q;
    // Next increment would land on the saturation value.
    run_sat   = (run_cnt >= (RUN_MAX - CNT_W'(1)));
    match     = (hi_len == exp_high) && (run_cnt == exp_low);
    match_inc = (match_cnt >= LOCK_N) ? LOCK_N : (match_cnt + MW'(1));

    case (state)
      ACQUIRE: begin
        if (rise) begin
          run_nx   = CNT_W'(1);
          state_nx = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_nx    = run_cnt;
          run_nx   = CNT_W'(1);
          state_nx = LOW;
        end else if (run_sat) begin
          run_nx   = RUN_MAX;
          set_err  = 1'b1;
          lk_nx    = 1'b0;
          match_nx = '0;
          state_nx = ACQUIRE;
        end else begin
          run_nx   = run_cnt + CNT_W'(1);
        end
      end
      LOW: begin
        if (rise) begin
          mh_nx    = hi_len;
          ml_nx    = run_cnt;
          mv_nx    = 1'b1;
          run_nx   = CNT_W'(1);
          state_nx = HIGH;
          if (match) begin
            match_nx = match_inc;
            if (match_inc == LOCK_N) lk_nx = 1'b1;
          end else begin
            match_nx = '0;
            lk_nx    = 1'b0;
            set_err  = 1'b1;
          end
        end else if (run_sat) begin
          run_nx   = RUN_MAX;
          set_err  = 1'b1;
          lk_nx    = 1'b0;
          match_nx = '0;
          state_nx = ACQUIRE;
        end else begin
          run_nx   = run_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ACQUIRE;
        run_nx   = '0;
      end
    endcase

    // Sticky error: a new error wins over a simultaneous clear.
    if (set_err)      err_nx = 1'b1;
    else if (err_clr) err_nx = 1'b0;

    // Disabled: drop back to acquisition, keep last measurement and error.
    if (!en) begin
      state_nx = ACQUIRE;
      run_nx   = '0;
      match_nx = '0;
      lk_nx    = 1'b0;
      mv_nx    = 1'b0;
      err_nx   = err;
    end
  end

  // State and output registers; div_q resets high so a true rise is required.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACQUIRE;
      div_q      <= 1'b1;
      run_cnt    <= '0;
      hi_len     <= '0;
      match_cnt  <= '0;
      meas_valid <= 1'b0;
      meas_high  <= '0;
      meas_low   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      div_q      <= div_in;
      run_cnt    <= run_nx;
      hi_len     <= hi_nx;
      match_cnt  <= match_nx;
      meas_valid <= mv_nx;
      meas_high  <= mh_nx;
      meas_low   <= ml_nx;
      locked     <= lk_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: doc/div_clock_monitor.md
Name: div_clock_monitor

Overview:
- Downstream checker for the register-generated divided clocks (div2/div4/div6 style) in the `clk` domain.
- Samples one divided-clock signal as data and measures high and low run lengths per full period, in `clk` cycles.
- Compares each measured period against programmed expected values and reports per-period measurements, a lock indication and a sticky error.
- Used at bring-up and in self-test to prove the divider restarts cleanly after reset and holds its duty cycle.

Parameters:
- CNT_W, 8, width of run-length counters and measurement outputs; legal range 2..16.
- LOCK_PERIODS, 4, consecutive matching periods required before `locked` asserts; legal range 1..255.

Ports:
- clk  input  1  sole clock; `div_in` is a register output in this domain.
- reset  input  1  synchronous, active-high reset.
- en  input  1  monitor enable; 0 forces re-acquire.
- div_in  input  1  divided clock under test, sampled as data on `clk` posedge.
- exp_high  input  CNT_W  expected high run length in `clk` cycles; held static while `en`=1.
- exp_low  input  CNT_W  expected low run length in `clk` cycles; held static while `en`=1.
- err_clr  input  1  clears sticky `err`.
- meas_valid  output  1  one-cycle pulse: a full period was measured.
- meas_high  output  CNT_W  high run length of the last full period.
- meas_low  output  CNT_W  low run length of the last full period.
- locked  output  1  LOCK_PERIODS consecutive matching periods seen.
- err  output  1  sticky: a mismatch or a saturated run occurred.

Behaviour:
- Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - meas_valid=0, meas_high=0, meas_low=0, locked=0, err=0.
  - State ACQUIRE, run_cnt=0, match_cnt=0.
  - Previous-sample register div_q=1, so a true 0->1 transition is needed after reset. A partial high phase in progress at reset release is discarded.
- Edge detection per cycle: rise = div_in & ~div_q; fall = ~div_in & div_q. div_q <= div_in every cycle.
- run_cnt counts consecutive samples at the current level, counting the edge sample as 1. It saturates at 2^CNT_W-1 and does not wrap.
- States:
  - ACQUIRE: wait for rise, then run_cnt<=1 and go to HIGH. meas_valid stays 0.
  - HIGH: while no edge, run_cnt increments (saturating). On fall: hi_len<=run_cnt, run_cnt<=1, go to LOW.
  - LOW: while no edge, run_cnt increments (saturating). On rise:
    - meas_high<=hi_len, meas_low<=run_cnt, meas_valid<=1.
    - run_cnt<=1, stay in the HIGH cycle path (next state HIGH).
- Latency: meas_valid is high the cycle after the sample that shows the closing rising edge.
- Check, evaluated on the same edge that generates meas_valid:
  - Match = (hi_len==exp_high) && (run_cnt==exp_low).
  - On match: match_cnt increments, saturating at LOCK_PERIODS. locked<=1 when the incremented value reaches LOCK_PERIODS, so locked rises in the same cycle as that meas_valid.
  - On mismatch: match_cnt<=0, locked<=0, err<=1.
- Saturation: a run reaching 2^CNT_W-1 sets err=1, clears locked and match_cnt, and returns the state to ACQUIRE with no meas_valid. A stuck signal therefore never produces a bogus measurement.
- err is sticky. err_clr=1 clears it next cycle. If err_clr and a new error occur in the same cycle, set wins (err stays 1).
- en=0:
  - State forced to ACQUIRE; run_cnt, match_cnt, locked and meas_valid forced to 0.
  - meas_high, meas_low and err hold their values. div_q keeps tracking div_in.
  - Re-enable behaves like reset release: the first rise starts acquisition.
- Reset asserted mid-period: all state and outputs return to reset values on that cycle. The interrupted period is never reported.
- A single-cycle glitch is a valid run of length 1 and is checked against expected values like any other run.

Test Plan:
- div2 pattern (1,0,1,0…), exp_high=1, exp_low=1, LOCK_PERIODS=4:
  - first meas_valid 1 cycle after the second sampled rise, with meas 1/1;
  - locked rises with the 4th meas_valid; err stays 0.
- div6 pattern (3 high/3 low), exp 3/3: every meas_valid shows 3/3, one pulse per 6 cycles. Then change the stimulus to 4 high/2 low:
  - next meas_valid shows 4/2 with err=1 and locked=0 the same cycle;
  - relock after 4 good periods.
- Reset pulsed during the 2nd high cycle of div4 (2/2), with div_in already high when reset releases:
  - no meas_valid until a full period completes after a fresh 0->1;
  - first report is 2/2.
- div_in held at 1 with CNT_W=4:
  - after 15 high samples, err=1, locked=0 and state returns to ACQUIRE;
  - no meas_valid is ever issued.
- err_clr: assert err_clr alone -> err=0 next cycle. Assert err_clr in the same cycle as a mismatching period -> err remains 1.
- en dropped for 3 cycles while locked with div4:
  - locked=0 immediately; meas_high/low hold 2/2;
  - after re-enable, the first meas_valid follows only after a complete new period.
